// File: rtl/xbar_ctrl_bbm.sv
// Crossbar control-bus generator: selects between GDS/SPI override pins and a
// registered configuration word, with break-before-make on every bus change.
module xbar_ctrl_bbm #(
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned BBM_CYCLES  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w,
    input  logic                 s,
    input  logic [2*SEL_W-1:0]   in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*SEL_W-1:0]   ctrl_out,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam int unsigned BusW = 2 * SEL_W;
    localparam int unsigned CntW = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntMax    = CntW'(BBM_CYCLES - 1);
    localparam logic [SEL_W-1:0] FieldBit0 = SEL_W'(1);
    localparam logic [SEL_W-1:0] FieldBit1 = SEL_W'(2);
    localparam logic [SEL_W-1:0] FieldMsb  = SEL_W'(1) << (SEL_W - 1);

    typedef enum logic {
        StStable,
        StBreak
    } state_e;

    function automatic logic is_onehot(input logic [SEL_W-1:0] f);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < SEL_W; i++) begin
            n += 32'(f[i]);
        end
        return n == 1;
    endfunction

    logic [SYNC_STAGES-1:0] w_sync, s_sync;
    logic                   w_q, s_q;
    logic [BusW-1:0]        cfg_q;
    logic [BusW-1:0]        ctrl_q, ctrl_d;
    logic [BusW-1:0]        target;
    logic [CntW-1:0]        cnt_q, cnt_d;
    state_e                 state_q, state_d;
    logic                   cfg_err_q;
    logic                   accept, in_ok;

    assign w_q = w_sync[SYNC_STAGES-1];
    assign s_q = s_sync[SYNC_STAGES-1];

    // w has priority over s, both over the stored configuration.
    always_comb begin
        target = cfg_q;
        if (w_q) begin
            target = {FieldBit0, FieldBit0};
        end else if (s_q) begin
            target = {FieldBit1, FieldBit1};
        end
    end

    assign in_ready = (state_q == StStable);
    assign busy     = (state_q == StBreak);
    assign ctrl_out = ctrl_q;
    assign cfg_err  = cfg_err_q;
    assign accept   = in_valid && in_ready;
    assign in_ok    = is_onehot(in[BusW-1:SEL_W]) && is_onehot(in[SEL_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_sync    <= '0;
            s_sync    <= '0;
            cfg_q     <= {FieldMsb, FieldMsb};
            cfg_err_q <= 1'b0;
        end else begin
            w_sync    <= {w_sync[SYNC_STAGES-2:0], w};
            s_sync    <= {s_sync[SYNC_STAGES-2:0], s};
            cfg_err_q <= accept && !in_ok;
            if (accept && in_ok) begin
                cfg_q <= in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBreak;
            cnt_q   <= CntMax;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // The bus only ever moves selection -> zero -> selection, never directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        unique case (state_q)
            StStable: begin
                if (target != ctrl_q) begin
                    ctrl_d  = '0;
                    cnt_d   = CntMax;
                    state_d = StBreak;
                end
            end
            StBreak: begin
                if (cnt_q == '0) begin
                    ctrl_d  = target;
                    state_d = StStable;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StBreak;
        endcase
    end

endmodule

// File: tb/tb_xbar_ctrl_bbm.sv
// Self-checking bench for xbar_ctrl_bbm: per-cycle comparison against a
// behavioural model plus directed literal expectations.
module tb_xbar_ctrl_bbm;

    localparam int SW   = 3;
    localparam int BBM  = 2;
    localparam int SYNC = 2;
    localparam int W    = 2 * SW;

    localparam logic [W-1:0] WTGT = W'((1 << SW) | 1);
    localparam logic [W-1:0] STGT = W'((2 << SW) | 2);
    localparam logic [W-1:0] DEF  = W'((1 << (W - 1)) | (1 << (SW - 1)));

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         w        = 1'b0;
    logic         s        = 1'b0;
    logic [W-1:0] in_w     = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] ctrl_out;
    logic         busy;
    logic         cfg_err;
    logic         run      = 1'b0;

    int checks = 0;
    int errors = 0;

    xbar_ctrl_bbm #(
        .SEL_W      (SW),
        .BBM_CYCLES (BBM),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w       (w),
        .s       (s),
        .in      (in_w),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ctrl_out(ctrl_out),
        .busy    (busy),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [W-1:0] x);
        return ($countones(x[W-1:SW]) == 1) && ($countones(x[SW-1:0]) == 1);
    endfunction

    // Model: pins seen SYNC edges late; bus zero for BBM edges on any change.
    logic [SYNC-1:0] m_w, m_s;
    logic [W-1:0]    m_cfg, m_bus, m_tgt;
    int              m_brk;
    logic            m_err;

    assign m_tgt = m_w[SYNC-1] ? WTGT : (m_s[SYNC-1] ? STGT : m_cfg);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_w   <= '0;
            m_s   <= '0;
            m_cfg <= DEF;
            m_bus <= '0;
            m_brk <= BBM;
            m_err <= 1'b0;
        end else begin
            m_w   <= {m_w[SYNC-2:0], w};
            m_s   <= {m_s[SYNC-2:0], s};
            m_err <= 1'b0;
            if (m_brk == 0 && in_valid) begin
                if (legal(in_w)) m_cfg <= in_w;
                else m_err <= 1'b1;
            end
            if (m_brk > 0) begin
                m_brk <= m_brk - 1;
                if (m_brk == 1) m_bus <= m_tgt;
            end else if (m_tgt != m_bus) begin
                m_bus <= '0;
                m_brk <= BBM;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (run) begin
            chk("model_ctrl", ctrl_out, m_bus);
            chk("model_busy", W'(busy), W'(m_brk > 0));
            chk("model_ready", W'(in_ready), W'(m_brk == 0));
            chk("model_err", W'(cfg_err), W'(m_err));
            checks++;
            if (!(ctrl_out == '0 || legal(ctrl_out))) begin
                errors++;
                $display("FAIL bus_shape: got %b required zero or two one-hot fields", ctrl_out);
            end
        end
    end

    task automatic offer(input logic [W-1:0] word);
        in_w     = word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 run = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hold", ctrl_out, '0);
        chk("rst_busy", W'(busy), W'(1));
        @(negedge clk);
        chk("rst_default", ctrl_out, 6'b100100);
        chk("rst_busy_fall", W'(busy), W'(0));
        chk("rst_ready", W'(in_ready), W'(1));

        offer(6'b010001);
        chk("cfg_before", ctrl_out, 6'b100100);
        @(negedge clk);
        chk("cfg_break1", ctrl_out, '0);
        chk("cfg_ready_low", W'(in_ready), W'(0));
        @(negedge clk);
        chk("cfg_break2", ctrl_out, '0);
        @(negedge clk);
        chk("cfg_new", ctrl_out, 6'b010001);

        offer(6'b010001);
        repeat (3) @(negedge clk);
        chk("rewrite_same", ctrl_out, 6'b010001);

        offer(6'b011001);
        chk("err_two_bits", W'(cfg_err), W'(1));
        @(negedge clk);
        chk("err_pulse_end", W'(cfg_err), W'(0));
        offer(6'b000100);
        chk("err_zero_field", W'(cfg_err), W'(1));
        @(negedge clk);
        chk("err_bus_kept", ctrl_out, 6'b010001);

        s = 1'b1;
        repeat (4) @(negedge clk);
        chk("s_break", ctrl_out, '0);
        @(negedge clk);
        chk("s_sel", ctrl_out, 6'b010010);
        w = 1'b1;
        repeat (5) @(negedge clk);
        chk("w_over_s", ctrl_out, 6'b001001);
        w = 1'b0;
        s = 1'b0;
        repeat (5) @(negedge clk);
        chk("ovr_release", ctrl_out, 6'b010001);
        w = 1'b1;
        s = 1'b1;
        repeat (5) @(negedge clk);
        chk("w_and_s", ctrl_out, 6'b001001);
        w = 1'b0;
        s = 1'b0;
        repeat (5) @(negedge clk);

        // s rises while the config-triggered break is running.
        offer(6'b100010);
        s = 1'b1;
        @(negedge clk);
        chk("brk_s_z1", ctrl_out, '0);
        @(negedge clk);
        chk("brk_s_z2", ctrl_out, '0);
        @(negedge clk);
        chk("brk_s_exit", ctrl_out, 6'b010010);

        s = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_in_break", W'(busy), W'(1));
        in_w     = 6'b001100;
        in_valid = 1'b1;
        @(negedge clk);
        chk("hold_not_ready", W'(in_ready), W'(0));
        @(negedge clk);
        chk("hold_exit", ctrl_out, 6'b100010);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_accepted_late", ctrl_out, 6'b100010);
        repeat (3) @(negedge clk);
        chk("hold_new", ctrl_out, 6'b001100);

        offer(6'b010001);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_brk_ctrl", ctrl_out, '0);
        chk("arst_brk_busy", W'(busy), W'(1));
        chk("arst_brk_ready", W'(in_ready), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst1_hold", ctrl_out, '0);
        @(negedge clk);
        chk("rst1_default", ctrl_out, 6'b100100);

        w = 1'b1;
        repeat (5) @(negedge clk);
        chk("ovr_before_rst", ctrl_out, 6'b001001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ovr_ctrl", ctrl_out, '0);
        chk("arst_ovr_busy", W'(busy), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_hold", ctrl_out, '0);
        @(negedge clk);
        chk("rst2_default", ctrl_out, 6'b100100);
        repeat (4) @(negedge clk);
        chk("rst2_w", ctrl_out, 6'b001001);
        w = 1'b0;
        repeat (6) @(negedge clk);
        chk("final", ctrl_out, 6'b100100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
